// File: rtl/lcd_pkg.sv
// Types and constants shared by the LCD text arbiter, its interface and its bench.
package lcd_pkg;

    localparam int LINE_CHARS = 16;

    typedef logic [8*LINE_CHARS-1:0] lcd_line_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        FINISH
    } lcd_arb_state_t;

    localparam lcd_line_t BLANK_LINE = {LINE_CHARS{8'h20}};

endpackage

// File: rtl/lcd_text_arbiter_if.sv
// Requester side and lcd_module side of the text arbiter, bundled as one interface.
interface lcd_text_arbiter_if
    import lcd_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0] req;
    lcd_line_t [N_REQ-1:0] req_line1;
    lcd_line_t [N_REQ-1:0] req_line2;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] done;
    logic busy;
    logic timeout_err;
    logic lcd_send;
    lcd_line_t lcd_line1;
    lcd_line_t lcd_line2;
    logic lcd_done;

    // The arbiter is the slave; application logic and lcd_module form the master side.
    modport slave (
        input  req, req_line1, req_line2, lcd_done,
        output ack, done, busy, timeout_err, lcd_send, lcd_line1, lcd_line2
    );

    modport master (
        output req, req_line1, req_line2, lcd_done,
        input  ack, done, busy, timeout_err, lcd_send, lcd_line1, lcd_line2
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit after ptr, wrapping around.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    int cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan farthest offset first so the candidate nearest ptr+1 is assigned last and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares one lcd_module text port among N_REQ requesters: round-robin grant,
// shadowed text lines, send/busy/idle handshake tracking and a watchdog.
module lcd_text_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 1000,
    parameter int DONE_TIMEOUT  = 5_000_000
) (
    input logic CLK,
    input logic RESET,
    lcd_text_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int MAX_T = (START_TIMEOUT > DONE_TIMEOUT) ? START_TIMEOUT : DONE_TIMEOUT;
    localparam int TMR_W = $clog2(MAX_T + 1);

    lcd_arb_state_t state, state_n;
    logic [N_REQ-1:0] ack_q, ack_n;
    logic [N_REQ-1:0] done_q, done_n;
    logic busy_q, busy_n;
    logic send_q, send_n;
    logic err_q, err_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] cur, cur_n;
    lcd_line_t line1_q, line1_n;
    lcd_line_t line2_q, line2_n;

    logic gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (bus.req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // All outputs are registered; ptr starts at the last index so requester 0 wins first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            err_q   <= 1'b0;
            timer   <= '0;
            ptr     <= IDX_W'(N_REQ - 1);
            cur     <= '0;
            line1_q <= BLANK_LINE;
            line2_q <= BLANK_LINE;
        end else begin
            state   <= state_n;
            ack_q   <= ack_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            send_q  <= send_n;
            err_q   <= err_n;
            timer   <= timer_n;
            ptr     <= ptr_n;
            cur     <= cur_n;
            line1_q <= line1_n;
            line2_q <= line2_n;
        end
    end

    always_comb begin
        state_n = state;
        ack_n   = '0;
        done_n  = '0;
        busy_n  = busy_q;
        send_n  = 1'b0;
        err_n   = err_q;
        timer_n = (timer != {TMR_W{1'b1}}) ? timer + 1'b1 : timer;
        ptr_n   = ptr;
        cur_n   = cur;
        line1_n = line1_q;
        line2_n = line2_q;

        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    line1_n          = bus.req_line1[gnt_idx];
                    line2_n          = bus.req_line2[gnt_idx];
                    ack_n[gnt_idx]   = 1'b1;
                    busy_n           = 1'b1;
                    ptr_n            = gnt_idx;
                    cur_n            = gnt_idx;
                    state_n          = SEND;
                end
            end
            SEND: begin
                send_n  = 1'b1;
                timer_n = '0;
                state_n = WAIT_BUSY;
            end
            // lcd_module signals acceptance by dropping sendingDone.
            WAIT_BUSY: begin
                if (!bus.lcd_done) begin
                    timer_n = '0;
                    state_n = WAIT_DONE;
                end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = FINISH;
                end
            end
            WAIT_DONE: begin
                if (bus.lcd_done) begin
                    state_n = FINISH;
                end else if (timer == TMR_W'(DONE_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done_n[cur] = 1'b1;
                busy_n      = 1'b0;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.ack         = ack_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.lcd_send    = send_q;
    assign bus.timeout_err = err_q;
    assign bus.lcd_line1   = line1_q;
    assign bus.lcd_line2   = line2_q;

endmodule

// File: doc/lcd_text_arbiter.md
# lcd_text_arbiter

Shares the single `lcd_module` text port between up to `N_REQ` independent requesters, for example the button handler, the counter display and the status reporter. It arbitrates round-robin and captures the winner's two 16-character lines into shadow registers. It then pulses `sendText`, tracks the LCD's `sendingDone` level through busy and back to idle, and returns a per-requester completion pulse. A watchdog guarantees forward progress if the LCD never responds. The block sits between the application logic and `lcd_module` in `main`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LINE_CHARS`, 16: characters per LCD line, 8 bits each.
- `START_TIMEOUT`, 1000: cycles allowed for `lcd_done` to fall after `lcd_send`.
- `DONE_TIMEOUT`, 5_000_000: cycles allowed for `lcd_done` to rise again (100 ms at 50 MHz).
- `CLK`, in, 1: system clock, 50 MHz.
- `RESET`, in, 1: one clock; reset is asynchronous and active-low.
- `req`, in, N_REQ: level request per requester, held until `ack`.
- `req_line1`, in, N_REQ×8·LINE_CHARS: line-1 text per requester; sampled only in the cycle that requester wins.
- `req_line2`, in, N_REQ×8·LINE_CHARS: line-2 text per requester; sampled the same way.
- `ack`, out, N_REQ: one-cycle pulse when that requester's text is captured.
- `done`, out, N_REQ: one-cycle pulse when that requester's transfer ends, whether OK or timed out.
- `busy`, out, 1: high from capture until the `done` pulse.
- `timeout_err`, out, 1: sticky; set by any watchdog expiry, cleared only by reset.
- `lcd_send`, out, 1: to `lcd_module.sendText`; one-cycle pulse.
- `lcd_line1`, out, 8·LINE_CHARS: to `lcd_module.line1`; stable for the whole transfer.
- `lcd_line2`, out, 8·LINE_CHARS: to `lcd_module.line2`; stable for the whole transfer.
- `lcd_done`, in, 1: from `lcd_module.sendingDone`; high means idle, low means sending.

## Operation
- **Reset values:**
  - `ack`, `done`, `busy`, `lcd_send`, `timeout_err` = 0.
  - `lcd_line1` and `lcd_line2` = all 0x20 (spaces).
  - State = IDLE.
  - Round-robin pointer = N_REQ−1, so requester 0 has the highest priority first.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit scanning from pointer+1 upward, with wrap-around.
  - Register the winner's lines into `lcd_line1`/`lcd_line2`, pulse `ack[w]`, set `busy`, set pointer = w, and go to SEND.
- **SEND:** `lcd_send`=1 for exactly this cycle; clear the timer; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `lcd_done`==0, go to WAIT_DONE and clear the timer.
  - Else if timer == START_TIMEOUT−1, set `timeout_err` and go to FINISH.
- **WAIT_DONE:**
  - If `lcd_done`==1, go to FINISH.
  - Else if timer == DONE_TIMEOUT−1, set `timeout_err` and go to FINISH.
- **FINISH:** pulse `done[w]`, clear `busy`, return to IDLE.
- **Request handling:**
  - A requester still holding `req` after its `done` re-enters arbitration, but ranks behind the others.
  - Dropping `req` before `ack` withdraws the request with no side effect.
  - `req` changes while `busy` are ignored until IDLE.
- **Watchdog:** a single counter, wide enough for max(START_TIMEOUT, DONE_TIMEOUT); it never wraps.
- **Asynchronous reset mid-transfer:** everything returns to its reset value immediately. No `done` is issued for the aborted transfer.

## Timing
- `req` seen high at edge k (state IDLE):
  - `ack`, `busy` and the new lines are visible after edge k+1.
  - `lcd_send` is high during the cycle after edge k+2.
- `lcd_done` sampled high in WAIT_DONE at edge m: `done` is high during the cycle after edge m+1, and `busy` falls at the same edge.
- Minimum `req`→`done` latency is 4 cycles, reached with an `lcd_done` that falls one cycle after `lcd_send` and rises one cycle later.
- Back-to-back grants: the next `ack` is possible at the edge after FINISH, giving 1 idle cycle minimum between transfers.
- `lcd_line*` change only on `ack` edges.

## Structure
- Package `lcd_pkg`:
  - `LINE_CHARS`.
  - `typedef logic [8*LINE_CHARS-1:0] lcd_line_t`.
  - The state enum `lcd_arb_state_t` {IDLE, SEND, WAIT_BUSY, WAIT_DONE, FINISH}.
  - `BLANK_LINE` constant (all 0x20).
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `ptr`; outputs are `gnt_valid` and `gnt_idx`.
- The FSM, shadow registers and watchdog live in `lcd_text_arbiter`.

## Test plan
- **Reset:** assert `RESET`=0 mid-WAIT_DONE → all outputs return to reset values asynchronously, `lcd_line1` = 16×0x20, and no `done` pulse.
- **Single request:** `req`=0001, LCD model drops `lcd_done` 3 cycles after send and raises it 20 cycles later → `ack[0]` at k+1, one `lcd_send` pulse, lines = requester 0 text, `done[0]` once, `timeout_err`=0.
- **Fairness:** `req`=1111 held continuously → grant order is 0,1,2,3,0, and each `done[i]` precedes the next `ack`.
- **Text capture:** change `req_line1[2]` the cycle after `ack[2]` → `lcd_line1` keeps the captured text until the next grant.
- **Start timeout:** `lcd_done` stuck at 1 → FINISH after START_TIMEOUT cycles, `done[w]` pulses, `timeout_err`=1 and stays 1.
- **Busy timeout:** `lcd_done` stuck at 0 → `done[w]` after DONE_TIMEOUT cycles, and the next pending request is still served.
